// File: rtl/fir_sm_fifo.sv
// FIR output sample FIFO: AXI-Stream push side, Wishbone-style pops at DATA (0x84), status/flush at STAT (0x88).
// Define FIR_SM_FIFO_LAST_EN to store tlast per entry and enable the head-last and frame_done status bits.
module fir_sm_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sm_tvalid,
  input  logic [31:0] sm_tdata,
  input  logic        sm_tlast,
  output logic        sm_tready,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [7:0]  req_adr,
  input  logic [31:0] req_dat,
  output logic        req_ack,
  output logic [31:0] req_rdata
);

  localparam logic [7:0]  ADR_DATA = 8'h84;
  localparam logic [7:0]  ADR_STAT = 8'h88;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
`ifdef FIR_SM_FIFO_LAST_EN
  localparam int EW = 33;
`else
  localparam int EW = 32;
`endif

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          accept, is_data, is_stat, rd_wait;
  logic          do_pop, do_push, do_flush, stat_rd;
  logic [EW-1:0] head, entry;
  logic [31:0]   stat;
  logic          unused_ok;
`ifdef FIR_SM_FIFO_LAST_EN
  logic          fd_q, fd_d;
`endif

  assign sm_tready = (cnt_q != CNT_FULL);
  assign req_ack   = ack_q;
  assign req_rdata = rdata_q;
  assign head      = mem_q[rp_q];

`ifdef FIR_SM_FIFO_LAST_EN
  assign entry     = {sm_tlast, sm_tdata};
  assign unused_ok = ^req_dat[31:1];
`else
  assign entry     = sm_tdata;
  assign unused_ok = ^{req_dat[31:1], sm_tlast};
`endif

  always_comb begin
    is_data  = (req_adr == ADR_DATA);
    is_stat  = (req_adr == ADR_STAT);
    // the ack cycle blocks acceptance so a held req_valid cannot pop twice
    accept   = req_valid & ~ack_q;
    rd_wait  = ~req_we & is_data & (cnt_q == '0);
    do_pop   = accept & ~req_we & is_data & ~rd_wait;
    stat_rd  = accept & ~req_we & is_stat;
    do_flush = accept & req_we & is_stat & req_dat[0];
    do_push  = sm_tvalid & sm_tready & ~do_flush;

    stat         = '0;
    stat[AW:0]   = cnt_q;
    stat[16]     = (cnt_q == '0);
    stat[17]     = ~sm_tready;
`ifdef FIR_SM_FIFO_LAST_EN
    stat[24]     = (cnt_q != '0) & head[32];
    stat[25]     = fd_q;
`endif

    wp_d = wp_q + AW'(do_push);
    rp_d = rp_q + AW'(do_pop);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (do_flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end

    ack_d   = accept & ~rd_wait;
    rdata_d = '0;
    if (do_pop)       rdata_d = head[31:0];
    else if (stat_rd) rdata_d = stat;

`ifdef FIR_SM_FIFO_LAST_EN
    fd_d = do_flush ? 1'b0 : ((fd_q & ~stat_rd) | (do_push & sm_tlast));
`endif
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
`ifdef FIR_SM_FIFO_LAST_EN
      fd_q    <= 1'b0;
`endif
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
`ifdef FIR_SM_FIFO_LAST_EN
      fd_q    <= fd_d;
`endif
    end
  end

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Bench for fir_sm_fifo: directed vector table, multi-cycle corner sequences, random traffic against a queue model.
module tb_fir_sm_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef FIR_SM_FIFO_LAST_EN
  localparam logic [31:0] FD25 = 32'h0200_0000;
  localparam logic [31:0] HL24 = 32'h0100_0000;
`else
  localparam logic [31:0] FD25 = 32'h0;
  localparam logic [31:0] HL24 = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sm_tvalid, sm_tlast, sm_tready;
  logic [31:0] sm_tdata;
  logic        req_valid, req_we, req_ack;
  logic [7:0]  req_adr;
  logic [31:0] req_dat, req_rdata;

  fir_sm_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .req_valid(req_valid), .req_we(req_we), .req_adr(req_adr), .req_dat(req_dat),
    .req_ack(req_ack), .req_rdata(req_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: FIFO contents as {last, data} plus the sticky frame flag
  logic [32:0] q[$];
  logic        fd = 1'b0;

  typedef struct {
    logic        is_req;
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic        last;
    logic [31:0] want;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(input logic is_req, input logic we, input logic [7:0] adr,
                              input logic [31:0] dat, input logic last, input logic [31:0] want);
    vec_t v;
    v.is_req = is_req; v.we = we; v.adr = adr; v.dat = dat; v.last = last; v.want = want;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  function automatic void model_push(input logic [31:0] d, input logic l);
    q.push_back({l, d});
`ifdef FIR_SM_FIFO_LAST_EN
    if (l) fd = 1'b1;
`endif
  endfunction

  function automatic logic [31:0] model_stat();
    logic [31:0] s;
    logic [32:0] h;
    s = '0;
    s[AW:0] = (AW+1)'(q.size());
    s[16]   = (q.size() == 0);
    s[17]   = (q.size() == DEPTH);
`ifdef FIR_SM_FIFO_LAST_EN
    if (q.size() != 0) begin
      h = q[0];
      s[24] = h[32];
    end
    s[25] = fd;
`else
    h = '0;
`endif
    return s;
  endfunction

  // expected read data of a request, applying its side effect to the model
  function automatic logic [31:0] model_req(input logic we, input logic [7:0] adr, input logic [31:0] dat);
    logic [32:0] e;
    logic [31:0] r;
    r = '0;
    if (!we && adr == 8'h84 && q.size() != 0) begin
      e = q.pop_front();
      r = e[31:0];
    end else if (!we && adr == 8'h88) begin
      r  = model_stat();
      fd = 1'b0;
    end else if (we && adr == 8'h88 && dat[0]) begin
      q.delete();
      fd = 1'b0;
    end
    return r;
  endfunction

  task automatic push(input logic [31:0] d, input logic l);
    logic acc;
    acc = (q.size() < DEPTH);
    check("tready_pre", 32'(sm_tready), 32'(acc));
    sm_tvalid = 1'b1; sm_tdata = d; sm_tlast = l;
    @(negedge clk);
    sm_tvalid = 1'b0; sm_tlast = 1'b0;
    if (acc) model_push(d, l);
  endtask

  // issue a request, wait for ack (bounded), hold req_valid through the ack cycle
  task automatic req_chk(input string name, input logic we, input logic [7:0] adr,
                         input logic [31:0] dat, input logic [31:0] want);
    int   lat;
    logic got;
    logic [31:0] rd;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat;
    lat = 0; got = 1'b0; rd = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = (req_ack === 1'b1);
    end
    if (got) rd = req_rdata;
    else lat = -1;
    check({name, "_lat"}, 32'(lat), 32'd1);
    check(name, rd, want);
    @(negedge clk);
    check({name, "_ackw"}, 32'(req_ack), 32'd0);
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0;
  endtask

  task automatic drain();
    logic [31:0] e;
    while (q.size() != 0) begin
      e = model_req(1'b0, 8'h84, 32'h0);
      req_chk("drain", 1'b0, 8'h84, 32'h0, e);
    end
  endtask

  task automatic push_pop(input logic [31:0] d, input logic l);
    logic acc;
    logic [31:0] e;
    acc = (q.size() < DEPTH);
    check("pp_tready", 32'(sm_tready), 32'(acc));
    e = model_req(1'b0, 8'h84, 32'h0);
    if (acc) model_push(d, l);
    sm_tvalid = 1'b1; sm_tdata = d; sm_tlast = l;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h84;
    @(negedge clk);
    sm_tvalid = 1'b0; sm_tlast = 1'b0;
    check("pp_ack", 32'(req_ack), 32'd1);
    check("pp_rdata", req_rdata, e);
    @(negedge clk);
    check("pp_ackw", 32'(req_ack), 32'd0);
    req_valid = 1'b0; req_adr = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dmy;
    int op;

    tbl[0]  = mk(1'b1, 1'b0, 8'h88, 32'h0,         1'b0, 32'h0001_0000);
    tbl[1]  = mk(1'b0, 1'b0, 8'h00, 32'h11,        1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 8'h00, 32'h22,        1'b0, 32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 8'h00, 32'h33,        1'b1, 32'h0);
    tbl[4]  = mk(1'b1, 1'b0, 8'h88, 32'h0,         1'b0, 32'h3 | FD25);
    tbl[5]  = mk(1'b1, 1'b0, 8'h88, 32'h0,         1'b0, 32'h3);
    tbl[6]  = mk(1'b1, 1'b1, 8'h88, 32'h2,         1'b0, 32'h0);
    tbl[7]  = mk(1'b1, 1'b0, 8'h84, 32'h0,         1'b0, 32'h11);
    tbl[8]  = mk(1'b1, 1'b0, 8'h84, 32'h0,         1'b0, 32'h22);
    tbl[9]  = mk(1'b1, 1'b0, 8'h88, 32'h0,         1'b0, 32'h1 | HL24);
    tbl[10] = mk(1'b1, 1'b0, 8'h84, 32'h0,         1'b0, 32'h33);
    tbl[11] = mk(1'b1, 1'b0, 8'h88, 32'h0,         1'b0, 32'h0001_0000);
    tbl[12] = mk(1'b1, 1'b1, 8'h90, 32'hFFFF_FFFF, 1'b0, 32'h0);
    tbl[13] = mk(1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[14] = mk(1'b1, 1'b1, 8'h84, 32'h55,        1'b0, 32'h0);
    tbl[15] = mk(1'b1, 1'b0, 8'h88, 32'h0,         1'b0, 32'h0001_0000);

    rst = 1'b1; sm_tvalid = 1'b0; sm_tdata = '0; sm_tlast = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tready", 32'(sm_tready), 32'd1);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_rdata", req_rdata, 32'h0);

    // directed table
    for (int i = 0; i < 16; i++) begin
      if (!tbl[i].is_req) push(tbl[i].dat, tbl[i].last);
      else begin
        dmy = model_req(tbl[i].we, tbl[i].adr, tbl[i].dat);
        req_chk($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].want);
      end
    end

    // fill to full, hold an extra sample, pop once and watch it get accepted
    for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i), 1'b0);
    check("full_tready", 32'(sm_tready), 32'd0);
    sm_tvalid = 1'b1; sm_tdata = 32'hF00D; sm_tlast = 1'b0;
    @(negedge clk);
    check("full_hold_tready", 32'(sm_tready), 32'd0);
    dmy = model_req(1'b0, 8'h88, 32'h0);
    req_chk("full_stat", 1'b0, 8'h88, 32'h0, 32'h0002_0008);
    dmy = model_req(1'b0, 8'h84, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h84;
    @(negedge clk);
    check("full_pop_ack", 32'(req_ack), 32'd1);
    check("full_pop_rdata", req_rdata, dmy);
    check("full_pop_tready", 32'(sm_tready), 32'd1);
    @(negedge clk);
    check("full_refill_tready", 32'(sm_tready), 32'd0);
    check("full_pop_ackw", 32'(req_ack), 32'd0);
    req_valid = 1'b0; sm_tvalid = 1'b0;
    model_push(32'hF00D, 1'b0);
    drain();

    // DATA read pending on an empty FIFO, then a push lands
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h84;
    repeat (3) begin
      @(negedge clk);
      check("wait_noack", 32'(req_ack), 32'd0);
    end
    sm_tvalid = 1'b1; sm_tdata = 32'hABCD; sm_tlast = 1'b0;
    @(negedge clk);
    sm_tvalid = 1'b0;
    check("wait_m1_noack", 32'(req_ack), 32'd0);
    @(negedge clk);
    check("wait_m2_ack", 32'(req_ack), 32'd1);
    check("wait_rdata", req_rdata, 32'hABCD);
    req_valid = 1'b0;
    @(negedge clk);
    check("wait_ackw", 32'(req_ack), 32'd0);
    dmy = model_req(1'b0, 8'h88, 32'h0);
    req_chk("wait_stat", 1'b0, 8'h88, 32'h0, 32'h0001_0000);

    // simultaneous push and pop at cnt = 4, across pointer wrap
    for (int i = 0; i < 4; i++) push($urandom(), 1'b0);
    for (int i = 0; i < 20; i++) push_pop($urandom(), 1'b0);
    dmy = model_req(1'b0, 8'h88, 32'h0);
    req_chk("pp_stat", 1'b0, 8'h88, 32'h0, 32'h0000_0004);
    drain();

    // flush with a concurrent last-flagged push that must be dropped
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(i), 1'b0);
    sm_tvalid = 1'b1; sm_tdata = 32'hDEAD; sm_tlast = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 8'h88; req_dat = 32'h1;
    @(negedge clk);
    sm_tvalid = 1'b0; sm_tlast = 1'b0;
    check("flush_ack", 32'(req_ack), 32'd1);
    @(negedge clk);
    check("flush_ackw", 32'(req_ack), 32'd0);
    req_valid = 1'b0; req_we = 1'b0; req_dat = '0;
    dmy = model_req(1'b1, 8'h88, 32'h1);
    dmy = model_req(1'b0, 8'h88, 32'h0);
    req_chk("flush_stat", 1'b0, 8'h88, 32'h0, 32'h0001_0000);

    // random traffic against the queue model
    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 4);
      if (op == 0) push($urandom(), ($urandom_range(0, 5) == 0));
      else if (op == 1 && q.size() != 0) begin
        dmy = model_req(1'b0, 8'h84, 32'h0);
        req_chk("rnd_data", 1'b0, 8'h84, 32'h0, dmy);
      end else if (op == 2 || op == 1) begin
        dmy = model_req(1'b0, 8'h88, 32'h0);
        req_chk("rnd_stat", 1'b0, 8'h88, 32'h0, dmy);
      end else if (op == 3 && q.size() != 0) push_pop($urandom(), ($urandom_range(0, 5) == 0));
      else push($urandom(), 1'b0);
    end
    drain();

    // reset while a DATA read is requested
    for (int i = 0; i < 3; i++) push(32'h700 + 32'(i), 1'b1);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h84;
    @(negedge clk);
    check("rstmid_noack", 32'(req_ack), 32'd0);
    check("rstmid_rdata", req_rdata, 32'h0);
    @(negedge clk);
    check("rstmid_noack2", 32'(req_ack), 32'd0);
    req_valid = 1'b0; req_adr = '0;
    rst = 1'b0;
    q.delete(); fd = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstpost_noack", 32'(req_ack), 32'd0);
    end
    check("rstpost_tready", 32'(sm_tready), 32'd1);
    dmy = model_req(1'b0, 8'h88, 32'h0);
    req_chk("rstpost_stat", 1'b0, 8'h88, 32'h0, 32'h0001_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
